// File: rtl/frame_rate_meter.sv
// frame_rate_meter: counts camera frame starts per sec_toggle window and latches the count as fps.
// Optional min/max tracking is compiled in with `define FRAME_RATE_MINMAX_EN.
module frame_rate_meter #(
  parameter int CNT_W             = 8,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
  parameter int SYNC_STAGES       = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sec_toggle,
  input  logic             cam_vsync,
  output logic [CNT_W-1:0] fps_out,
  output logic             fps_valid,
  output logic             cam_stalled
`ifdef FRAME_RATE_MINMAX_EN
  ,
  output logic [CNT_W-1:0] fps_min,
  output logic [CNT_W-1:0] fps_max
`endif
);

  localparam logic VS_IDLE = !VSYNC_ACTIVE_HIGH;

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] vs_sync_q;
  logic                   vs_prev_q;
  logic                   sec_d_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       fps_q;
  logic                   valid_q;
  logic                   stalled_q;
  logic                   vs_now;
  logic                   frame_evt;
  logic                   tick;
  logic [CNT_W-1:0]       restart_d;
`ifdef FRAME_RATE_MINMAX_EN
  logic [CNT_W-1:0]       min_q;
  logic [CNT_W-1:0]       max_q;
`endif

  assign vs_now    = vs_sync_q[SYNC_STAGES-1];
  assign frame_evt = VSYNC_ACTIVE_HIGH ? (vs_now & ~vs_prev_q) : (~vs_now & vs_prev_q);
  assign tick      = sec_toggle & ~sec_d_q;

  // Saturating increment; a frame landing on the tick cycle opens the new window at 1.
  assign cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
  assign restart_d = frame_evt ? CNT_W'(1) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      vs_sync_q <= {SYNC_STAGES{VS_IDLE}};
      vs_prev_q <= VS_IDLE;
      sec_d_q   <= 1'b1;
      cnt_q     <= '0;
      fps_q     <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
`ifdef FRAME_RATE_MINMAX_EN
      min_q     <= '1;
      max_q     <= '0;
`endif
    end else begin
      vs_sync_q <= {vs_sync_q[SYNC_STAGES-2:0], cam_vsync};
      vs_prev_q <= vs_now;
      sec_d_q   <= sec_toggle;
      valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (tick) begin
            state_q <= MEASURE;
            cnt_q   <= restart_d;
          end
        end
        MEASURE: begin
          if (tick) begin
            fps_q     <= cnt_q;
            valid_q   <= 1'b1;
            stalled_q <= (cnt_q == '0);
            cnt_q     <= restart_d;
`ifdef FRAME_RATE_MINMAX_EN
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
`endif
          end else if (frame_evt) begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fps_out     = fps_q;
  assign fps_valid   = valid_q;
  assign cam_stalled = stalled_q;
`ifdef FRAME_RATE_MINMAX_EN
  assign fps_min     = min_q;
  assign fps_max     = max_q;
`endif

endmodule

// File: tb/tb_frame_rate_meter.sv
// Bench for frame_rate_meter: random-gap vsync pulses, window reports predicted from event times.
`timescale 1ns/1ps
module tb_frame_rate_meter;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sec_toggle = 1'b1;
  logic cam_vsync = 1'b0;
  logic cam_vsync_n;
  logic [7:0] fps8;
  logic       v8, st8;
  logic [3:0] fps4;
  logic       v4, st4;
`ifdef FRAME_RATE_MINMAX_EN
  logic [7:0] min8, max8;
  logic [3:0] min4, max4;
`endif

  assign cam_vsync_n = ~cam_vsync;

  frame_rate_meter #(.CNT_W(8), .VSYNC_ACTIVE_HIGH(1'b1), .SYNC_STAGES(SYNC)) dut8 (
    .clk(clk), .reset(reset), .sec_toggle(sec_toggle), .cam_vsync(cam_vsync),
    .fps_out(fps8), .fps_valid(v8), .cam_stalled(st8)
`ifdef FRAME_RATE_MINMAX_EN
    , .fps_min(min8), .fps_max(max8)
`endif
  );

  // Narrow counter on the inverted vsync: same frame starts, falling-edge polarity.
  frame_rate_meter #(.CNT_W(4), .VSYNC_ACTIVE_HIGH(1'b0), .SYNC_STAGES(SYNC)) dut4 (
    .clk(clk), .reset(reset), .sec_toggle(sec_toggle), .cam_vsync(cam_vsync_n),
    .fps_out(fps4), .fps_valid(v4), .cam_stalled(st4)
`ifdef FRAME_RATE_MINMAX_EN
    , .fps_min(min4), .fps_max(max4)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: frame event edge numbers, window boundaries, last reported values.
  int ev_q[$];
  int last_tick = 0;
  bit armed = 1'b0;
  int exp_fps = 0;
  bit exp_st = 1'b0;
  int exp_min = 255;
  int exp_max = 0;
  int nchecks = 0;
  int nerr = 0;

  function automatic logic [7:0] sat8(input int n);
    return (n > 255) ? 8'd255 : 8'(n);
  endfunction

  function automatic logic [3:0] sat4(input int n);
    return (n > 15) ? 4'd15 : 4'(n);
  endfunction

  function automatic int count_window(input int t0, input int t1);
    int c = 0;
    foreach (ev_q[i]) if (ev_q[i] >= t0 && ev_q[i] < t1) c++;
    return c;
  endfunction

  task automatic model_clear();
    ev_q.delete();
    armed = 1'b0;
    exp_fps = 0;
    exp_st = 1'b0;
    exp_min = 255;
    exp_max = 0;
  endtask

  // All stimulus tasks start and end 1ns after a rising clock edge.
  task automatic pulse();
    cam_vsync = 1'b1;
    ev_q.push_back(cyc + SYNC + 1);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1 cam_vsync = 1'b0;
    repeat ($urandom_range(2, 4)) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) pulse();
  endtask

  task automatic end_window(input string tag);
    int t, n, nv8, nv4;
    bit rep;
    logic [7:0] g8;
    logic [3:0] g4;
    logic gs8, gs4;
    if (sec_toggle) begin
      sec_toggle = 1'b0;
      @(posedge clk); #1;
    end
    nchecks++;
    if (fps8 !== sat8(exp_fps) || st8 !== exp_st) begin
      nerr++;
      $display("FAIL %s_hold8 fps=%0d stalled=%0b expected fps=%0d stalled=%0b", tag, fps8, st8, sat8(exp_fps), exp_st);
    end
    nchecks++;
    if (fps4 !== sat4(exp_fps) || st4 !== exp_st) begin
      nerr++;
      $display("FAIL %s_hold4 fps=%0d stalled=%0b expected fps=%0d stalled=%0b", tag, fps4, st4, sat4(exp_fps), exp_st);
    end
    sec_toggle = 1'b1;
    t = cyc + 1;
    rep = armed;
    n = count_window(last_tick, t);
    nv8 = 0; nv4 = 0; g8 = '0; g4 = '0; gs8 = 1'b0; gs4 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (v8) begin nv8++; g8 = fps8; gs8 = st8; end
      if (v4) begin nv4++; g4 = fps4; gs4 = st4; end
    end
    if (rep) begin
      exp_fps = n;
      exp_st = (n == 0);
      if (int'(sat8(n)) < exp_min) exp_min = int'(sat8(n));
      if (int'(sat8(n)) > exp_max) exp_max = int'(sat8(n));
    end
    armed = 1'b1;
    last_tick = t;
    nchecks++;
    if (nv8 != (rep ? 1 : 0)) begin
      nerr++;
      $display("FAIL %s_valid8 pulses=%0d expected=%0d", tag, nv8, rep ? 1 : 0);
    end
    nchecks++;
    if (nv4 != (rep ? 1 : 0)) begin
      nerr++;
      $display("FAIL %s_valid4 pulses=%0d expected=%0d", tag, nv4, rep ? 1 : 0);
    end
    if (rep) begin
      nchecks++;
      if (g8 !== sat8(n) || gs8 !== (n == 0)) begin
        nerr++;
        $display("FAIL %s_fps8 fps=%0d stalled=%0b expected fps=%0d stalled=%0b", tag, g8, gs8, sat8(n), n == 0);
      end
      nchecks++;
      if (g4 !== sat4(n) || gs4 !== (n == 0)) begin
        nerr++;
        $display("FAIL %s_fps4 fps=%0d stalled=%0b expected fps=%0d stalled=%0b", tag, g4, gs4, sat4(n), n == 0);
      end
    end
`ifdef FRAME_RATE_MINMAX_EN
    nchecks++;
    if (min8 !== 8'(exp_min) || max8 !== 8'(exp_max)) begin
      nerr++;
      $display("FAIL %s_minmax min=%0d max=%0d expected min=%0d max=%0d", tag, min8, max8, exp_min, exp_max);
    end
`endif
    @(posedge clk); #1 sec_toggle = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int nv;
    sec_toggle = 1'b1;
    do_reset();
    nchecks++;
    if (fps8 !== 8'd0 || v8 !== 1'b0 || st8 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_values fps=%0d valid=%0b stalled=%0b expected 0 0 0", fps8, v8, st8);
    end
`ifdef FRAME_RATE_MINMAX_EN
    nchecks++;
    if (min8 !== 8'hFF || max8 !== 8'h00) begin
      nerr++;
      $display("FAIL reset_minmax min=%0d max=%0d expected min=255 max=0", min8, max8);
    end
`endif
    nv = 0;
    repeat (100) begin
      @(negedge clk);
      if (v8 || v4) nv++;
    end
    @(posedge clk); #1;
    nchecks++;
    if (nv != 0 || fps8 !== 8'd0) begin
      nerr++;
      $display("FAIL reset_hold_high valid_cycles=%0d fps=%0d expected 0 and 0", nv, fps8);
    end
  endtask

  task automatic test_sequence();
    pulses(5);
    end_window("first_tick");
    pulses(30);
    end_window("win30");
    repeat ($urandom_range(10, 30)) @(posedge clk);
    #1;
    end_window("win0_stall");
    pulses(7);
    end_window("win7_unstall");
  endtask

  task automatic test_coincide();
    pulses(12);
    // Rise two cycles before sec_toggle so the synchronised event lands on the tick cycle.
    cam_vsync = 1'b1;
    ev_q.push_back(cyc + SYNC + 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    end_window("coincide12");
    cam_vsync = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    pulses(9);
    end_window("coincide_next10");
  endtask

  task automatic test_saturate();
    pulses(20);
    end_window("sat20");
  endtask

  task automatic test_reset_mid();
    pulses(8);
    #2 reset = 1'b0;
    model_clear();
    #1;
    nchecks++;
    if (fps8 !== 8'd0 || st8 !== 1'b0 || v8 !== 1'b0 || fps4 !== 4'd0 || st4 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_async fps8=%0d st8=%0b v8=%0b fps4=%0d st4=%0b expected all 0", fps8, st8, v8, fps4, st4);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    pulses(4);
    end_window("post_reset_first");
    pulses(6);
    end_window("post_reset_second");
  endtask

  task automatic test_minmax();
    do_reset();
    pulses(3);
    end_window("mm_arm");
    pulses(30);
    end_window("mm30");
    pulses(25);
    end_window("mm25");
    pulses(31);
    end_window("mm31");
`ifdef FRAME_RATE_MINMAX_EN
    nchecks++;
    if (min8 !== 8'd25 || max8 !== 8'd31) begin
      nerr++;
      $display("FAIL minmax_final min=%0d max=%0d expected min=25 max=31", min8, max8);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_coincide();
    test_saturate();
    test_reset_mid();
    test_minmax();
    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

// File: doc/frame_rate_meter.md
Name: frame_rate_meter

Overview:
- Measures the camera frame rate by counting frame-start pulses over a one-second window.
- The window is defined by the slow toggle output of the 1 Hz clock divider.
- Sits directly downstream of the divider and beside the camera capture path.
- Reports a latched frames-per-second value with a one-cycle valid strobe, a stall flag, and optional min/max tracking for the debug display/LEDs.

Parameters:
- CNT_W, 8: width of the frame counter and fps outputs.
- VSYNC_ACTIVE_HIGH, 1: 1 = frame start is the rising edge of cam_vsync; 0 = the falling edge.
- SYNC_STAGES, 2: flip-flop stages synchronising cam_vsync into clk (legal 2..4).

Ports:
- clk  input  1  system clock, same clock that drives the 1 Hz divider.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sec_toggle  input  1  slow square wave from the divider, clk-domain register; each rising edge ends a window.
- cam_vsync  input  1  camera VSYNC, asynchronous to clk.
- fps_out  output  CNT_W  frame count of the last complete window.
- fps_valid  output  1  one-cycle pulse when fps_out updates.
- cam_stalled  output  1  high while the last complete window counted zero frames.
- fps_min  output  CNT_W  present only with the optional feature.
- fps_max  output  CNT_W  present only with the optional feature.

Behaviour:
- Reset (reset=0, async) clears all state:
  - fps_out=0, fps_valid=0, cam_stalled=0, frame counter=0, state=IDLE.
  - Synchroniser flops reset to the inactive vsync level.
  - sec_toggle delay flop resets to 1, so a high sec_toggle at reset release is not an edge.
- Vsync path:
  - SYNC_STAGES-flop synchroniser, then one edge-detect register.
  - A frame event is the active edge per VSYNC_ACTIVE_HIGH.
  - Latency from the cam_vsync edge to the counter increment is SYNC_STAGES+1 clk cycles.
- Window edge: tick = sec_toggle & ~sec_toggle_d, evaluated every clk.
- State machine:
  - IDLE: frame events ignored, counter held at 0. On tick go to MEASURE and clear the counter; no fps_valid (partial window discarded).
  - MEASURE: each frame event increments the counter, saturating at 2^CNT_W-1 (no wrap).
  - MEASURE on tick, all in the same cycle:
    - fps_out <= counter.
    - fps_valid pulses for exactly that cycle.
    - cam_stalled <= (counter==0).
    - Counter restarts.
    - Remain in MEASURE.
- Simultaneous tick and frame event: the event belongs to the new window; the counter loads 1, and fps_out takes the pre-increment count.
- fps_out and cam_stalled hold between ticks.
- Reset mid-window returns to IDLE; the next complete window is the first reported.
- No handshake back-pressure: the consumer must sample fps_out on fps_valid or any time after.

Optional Feature:
- Macro FRAME_RATE_MINMAX_EN.
- Defined:
  - fps_min and fps_max ports exist.
  - Reset values: fps_min=all ones, fps_max=0.
  - On each fps_valid cycle they update as min/max of themselves and the new fps_out, visible the same cycle as fps_out.
  - A zero-frame window updates fps_min to 0.
- Undefined: the ports, registers and compare logic are absent; all other behaviour is identical.

Test Plan:
- Reset release with sec_toggle=1, then hold high for 100 cycles -> no tick, state IDLE, fps_out=0, fps_valid never high.
- Driving sequence:
  - First sec_toggle rise after 5 vsync pulses -> no fps_valid.
  - Then 30 vsync pulses and a second rise -> single-cycle fps_valid, fps_out=30, cam_stalled=0.
- Third window with 0 vsync pulses -> fps_out=0, cam_stalled=1.
- Fourth window with 7 pulses -> cam_stalled returns to 0.
- Vsync edge timed so its synchronised event coincides with the tick cycle, after 12 earlier pulses -> fps_out=12; next report counts that event (e.g. 1+9 further pulses gives 10).
- CNT_W=4 with 20 pulses in one window -> fps_out=15 (saturated, no wrap).
- Reset asserted mid-window after 8 pulses -> outputs zero immediately (asynchronously); the first report after release comes from the second post-reset tick.
- With FRAME_RATE_MINMAX_EN defined and windows of 30, 25, 31 frames -> after the third fps_valid, fps_min=25 and fps_max=31.
- Without FRAME_RATE_MINMAX_EN -> the module elaborates without the fps_min/fps_max ports.
